// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word store, load port, fixed-latency response pipe.
// Store starts as all NOP; program words arrive through the load port.
module instr_mem_responder #(
  parameter int DEPTH_WORDS = 16,
  parameter int LATENCY     = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           req_valid,
  input  logic [63:0]                    req_addr,
  output logic                           req_ready,
  input  logic                           flush,
  output logic                           rsp_valid,
  output logic [31:0]                    rsp_instr,
  output logic [63:0]                    rsp_addr,
  output logic                           rsp_err,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
  input  logic [31:0]                    load_data
);

  localparam int          IW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [63:0] RANGE = 64'(DEPTH_WORDS) << 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        err;
  } ent_t;

  logic [31:0] mem_q [DEPTH_WORDS] = '{default: NOP};

  logic               accept;
  logic               req_err;
  ent_t               new_e;
  logic [LATENCY-1:0] v_q, v_d;
  ent_t               ent_q [LATENCY];
  ent_t               ent_d [LATENCY];
  logic [LATENCY-1:0] chain_v;
  ent_t               chain_e [LATENCY];

  assign req_ready = !load_en;
  assign accept    = req_valid && req_ready && !flush;
  assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr >= RANGE);

  always_comb begin
    new_e       = '0;
    new_e.addr  = req_addr;
    new_e.err   = req_err;
    new_e.instr = req_err ? NOP : mem_q[req_addr[IW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end
  end

  // Payload only moves with a valid entry, so outputs hold across bubbles.
  always_comb begin
    chain_v    = '0;
    chain_e[0] = new_e;
    chain_v[0] = accept;
    for (int i = 1; i < LATENCY; i++) begin
      chain_v[i] = v_q[i-1];
      chain_e[i] = ent_q[i-1];
    end
    v_d   = '0;
    ent_d = ent_q;
    for (int i = 0; i < LATENCY; i++) begin
      v_d[i] = chain_v[i] && !flush;
      if (v_d[i]) begin
        ent_d[i] = chain_e[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      ent_q <= '{default: '0};
    end else begin
      v_q   <= v_d;
      ent_q <= ent_d;
    end
  end

  assign rsp_valid = v_q[LATENCY-1];
  assign rsp_instr = ent_q[LATENCY-1].instr;
  assign rsp_addr  = ent_q[LATENCY-1].addr;
  assign rsp_err   = ent_q[LATENCY-1].err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench: three responders (latency 1..3) on shared stimulus vs. a time-indexed model.
module tb_instr_mem_responder;

  localparam int          MAXN = 2048;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        flush;
  logic        load_en;
  logic [3:0]  load_idx;
  logic [31:0] load_data;

  logic        rr [3];
  logic        rv [3];
  logic [31:0] ri [3];
  logic [63:0] ra [3];
  logic        re [3];

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(rr[0]), .flush(flush),
    .rsp_valid(rv[0]), .rsp_instr(ri[0]), .rsp_addr(ra[0]),
    .rsp_err(re[0]), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data)
  );

  instr_mem_responder #(.DEPTH_WORDS(16), .LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(rr[1]), .flush(flush),
    .rsp_valid(rv[1]), .rsp_instr(ri[1]), .rsp_addr(ra[1]),
    .rsp_err(re[1]), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data)
  );

  instr_mem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(rr[2]), .flush(flush),
    .rsp_valid(rv[2]), .rsp_instr(ri[2]), .rsp_addr(ra[2]),
    .rsp_err(re[2]), .load_en(load_en), .load_idx(load_idx),
    .load_data(load_data)
  );

  // Reference: log of what was accepted at each edge, plus flush edges.
  logic [31:0] mem_m [16];
  int          n        = 0;
  int          rst_mark = 0;
  bit          acc_v [MAXN];
  logic [63:0] acc_a [MAXN];
  logic [31:0] acc_i [MAXN];
  bit          acc_e [MAXN];
  bit          fl    [MAXN];
  logic [31:0] last_i [3];
  logic [63:0] last_a [3];
  logic        last_e [3];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  task automatic edge_upd();
    n++;
    acc_v[n] = 1'b0;
    fl[n]    = reset_n && flush;
    if (reset_n && req_valid && !load_en && !flush) begin
      acc_v[n] = 1'b1;
      acc_a[n] = req_addr;
      acc_e[n] = (req_addr % 4 != 0) || (req_addr >= 64'd64);
      if (acc_e[n]) acc_i[n] = NOP;
      else acc_i[n] = mem_m[int'(req_addr / 4)];
    end
    if (load_en) mem_m[load_idx] = load_data;
  endtask

  task automatic check_all();
    for (int j = 0; j < 3; j++) begin
      int  k;
      bit  ev;
      k  = n - j;
      ev = reset_n && (k >= 1) && (k > rst_mark) && acc_v[k];
      for (int f = k + 1; f <= n; f++) begin
        if (ev && fl[f]) ev = 1'b0;
      end
      if (ev) begin
        last_i[j] = acc_i[k];
        last_a[j] = acc_a[k];
        last_e[j] = acc_e[k];
      end
      chk($sformatf("L%0d ready", j + 1), 64'(rr[j]), 64'(!load_en));
      chk($sformatf("L%0d valid", j + 1), 64'(rv[j]), 64'(ev));
      chk($sformatf("L%0d instr", j + 1), 64'(ri[j]), 64'(last_i[j]));
      chk($sformatf("L%0d addr", j + 1), ra[j], last_a[j]);
      chk($sformatf("L%0d err", j + 1), 64'(re[j]), 64'(last_e[j]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_upd();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(bit v, logic [63:0] a, bit f,
                       bit le, logic [3:0] li, logic [31:0] ld);
    req_valid = v;
    req_addr  = a;
    flush     = f;
    load_en   = le;
    load_idx  = li;
    load_data = ld;
  endtask

  task automatic idle(int cycles);
    drive(0, 64'h0, 0, 0, 4'h0, 32'h0);
    repeat (cycles) step();
  endtask

  // Mid-cycle asynchronous reset: outputs must drop before any edge.
  task automatic mid_reset(int cycles);
    #2;
    reset_n  = 1'b0;
    rst_mark = n;
    for (int j = 0; j < 3; j++) begin
      last_i[j] = '0;
      last_a[j] = '0;
      last_e[j] = 1'b0;
    end
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("L%0d async clr", j + 1), 64'(rv[j]), 64'h0);
    end
    repeat (cycles) step();
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout edge=%0d", n);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem_m[i] = NOP;
    for (int j = 0; j < 3; j++) begin
      last_i[j] = '0;
      last_a[j] = '0;
      last_e[j] = 1'b0;
    end
    reset_n = 1'b0;
    drive(1, 64'h0, 0, 0, 4'h0, 32'h0);
    @(negedge clk);
    check_all();
    repeat (3) step();
    reset_n = 1'b1;

    drive(1, 64'h8, 0, 0, 4'h0, 32'h0);
    step();
    idle(3);

    drive(0, 64'h0, 0, 1, 4'd3, 32'h0050_0093);
    step();
    drive(1, 64'hC, 0, 0, 4'h0, 32'h0);
    step();
    idle(3);

    for (int i = 0; i < 4; i++) begin
      drive(1, 64'(4 * i), 0, 0, 4'h0, 32'h0);
      step();
    end
    idle(3);

    drive(1, 64'h6, 0, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'h40, 0, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'h3C, 0, 0, 4'h0, 32'h0);
    step();
    idle(3);

    drive(1, 64'h0, 0, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'h4, 0, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'h8, 1, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'h10, 0, 0, 4'h0, 32'h0);
    step();
    idle(3);

    drive(1, 64'h14, 0, 1, 4'd5, 32'hDEAD_BEEF);
    step();
    idle(3);
    drive(1, 64'h18, 0, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'h14, 1, 1, 4'd6, 32'h1234_5678);
    step();
    drive(1, 64'h18, 0, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'h14, 0, 0, 4'h0, 32'h0);
    step();
    idle(3);

    drive(1, 64'h0, 0, 0, 4'h0, 32'h0);
    step();
    drive(1, 64'h4, 0, 0, 4'h0, 32'h0);
    step();
    mid_reset(2);
    idle(4);

    for (int c = 0; c < 500; c++) begin
      logic [63:0] a;
      int          r;
      r = int'($urandom_range(0, 9));
      if (r <= 6) a = 64'($urandom_range(0, 15)) << 2;
      else if (r == 7) a = (64'($urandom_range(0, 15)) << 2) | 64'($urandom_range(1, 3));
      else if (r == 8) a = 64'h40 + 64'($urandom_range(0, 255));
      else a = {$urandom, $urandom};
      drive(($urandom_range(0, 3) != 0), a,
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0),
            4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 149) == 0) mid_reset(1);
      step();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
